// File: rtl/gene_pkg.sv
// gene_pkg: shared definitions for the gene-network sweep controller.
//   GENE_W               default network state width
//   KIND_FIXED/CYCLE     encoding of res_kind
//   gsc_state_e          sweep FSM states
package gene_pkg;

    localparam int   GENE_W     = 8;
    localparam logic KIND_FIXED = 1'b0;
    localparam logic KIND_CYCLE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        MEASURE,
        REPORT,
        DONE
    } gsc_state_e;

endpackage

// File: rtl/gene_visited_map.sv
// gene_visited_map: 2^W-bit visited bitmap for one trajectory.
//   clk, rst_n    clock, async active-low reset (clears the map)
//   i_clr         clear the whole map in one cycle (wins over i_set)
//   i_set         set bit i_set_idx
//   i_rd_idx      combinational read index
//   o_rd          bit at i_rd_idx
module gene_visited_map #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_set,
    input  logic [W-1:0] i_set_idx,
    input  logic [W-1:0] i_rd_idx,
    output logic         o_rd
);

    logic [2**W-1:0] r_map;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_map <= '0;
        end else if (i_clr) begin
            r_map <= '0;
        end else if (i_set) begin
            r_map[i_set_idx] <= 1'b1;
        end
    end

    assign o_rd = r_map[i_rd_idx];

endmodule

// File: rtl/gene_sweep_ctrl.sv
// gene_sweep_ctrl: sweeps initial states init_lo..init_hi through an external
// boolean-network next-state function, detects the attractor reached from each
// one and streams a classified result over a valid/ready port.
//   start, init_lo, init_hi     sweep request (lo/hi sampled on start)
//   net_cur / net_next          state presented to the network / f(net_cur)
//   res_valid/res_ready         result handshake
//   res_init/kind/attr/steps    result payload, held while stalled
//   fixed_cnt, cycle_cnt        accepted results of this sweep by kind
//   busy, done                  sweep in progress / one-cycle end pulse
// Optional: define GSC_CYCLE_LEN_EN to add the MEASURE state and res_cyc_len.
//
// state   | meaning
// IDLE    | waiting for start
// LOAD    | present next initial state, clear visited map
// RUN     | one network transition per cycle until a revisit
// MEASURE | walk the attractor once to count its length (optional)
// REPORT  | hold result until accepted
// DONE    | one-cycle end-of-sweep pulse
module gene_sweep_ctrl
    import gene_pkg::*;
#(
    parameter int W     = GENE_W,
    parameter int CNT_W = W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     init_lo,
    input  logic [W-1:0]     init_hi,
    output logic [W-1:0]     net_cur,
    input  logic [W-1:0]     net_next,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W-1:0]     res_init,
    output logic             res_kind,
    output logic [W-1:0]     res_attr,
    output logic [CNT_W-1:0] res_steps,
    output logic [CNT_W-1:0] fixed_cnt,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             busy,
    output logic             done
`ifdef GSC_CYCLE_LEN_EN
    ,output logic [CNT_W-1:0] res_cyc_len
`endif
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    gsc_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_iter, r_hi, r_steps, r_fixed, r_cycle;
    logic [W-1:0]     r_cur, r_init, r_attr;
    logic             r_kind;
    logic             w_self, w_seen, w_hs;
`ifdef GSC_CYCLE_LEN_EN
    logic [CNT_W-1:0] r_len;
`endif

    gene_visited_map #(.W(W)) u_map (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (r_state == LOAD),
        .i_set     (r_state == RUN),
        .i_set_idx (r_cur),
        .i_rd_idx  (net_next),
        .o_rd      (w_seen)
    );

    assign w_self = (net_next == r_cur);
    assign w_hs   = (r_state == REPORT) && res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = (init_lo > init_hi) ? DONE : LOAD;
            LOAD:    w_state_nxt = RUN;
            RUN: begin
`ifdef GSC_CYCLE_LEN_EN
                if (w_self)      w_state_nxt = REPORT;
                else if (w_seen) w_state_nxt = MEASURE;
`else
                if (w_self || w_seen) w_state_nxt = REPORT;
`endif
            end
`ifdef GSC_CYCLE_LEN_EN
            MEASURE: if (net_next == r_attr) w_state_nxt = REPORT;
`endif
            REPORT:  if (res_ready) w_state_nxt = (r_iter == r_hi) ? DONE : LOAD;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iter  <= '0;
            r_hi    <= '0;
            r_cur   <= '0;
            r_init  <= '0;
            r_attr  <= '0;
            r_kind  <= KIND_FIXED;
            r_steps <= '0;
            r_fixed <= '0;
            r_cycle <= '0;
`ifdef GSC_CYCLE_LEN_EN
            r_len   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    // Iterator is one bit wider so hi = all-ones never wraps.
                    r_iter  <= {1'b0, init_lo};
                    r_hi    <= {1'b0, init_hi};
                    r_fixed <= '0;
                    r_cycle <= '0;
                end
                LOAD: begin
                    r_cur   <= r_iter[W-1:0];
                    r_init  <= r_iter[W-1:0];
                    r_steps <= '0;
                end
                RUN: begin
                    if (w_self) begin
                        r_kind <= KIND_FIXED;
                        r_attr <= r_cur;
`ifdef GSC_CYCLE_LEN_EN
                        r_len  <= ONE;
`endif
                    end else if (w_seen) begin
                        r_kind <= KIND_CYCLE;
                        r_attr <= net_next;
`ifdef GSC_CYCLE_LEN_EN
                        // Start the measuring walk from the attractor entry.
                        r_cur  <= net_next;
                        r_len  <= '0;
`endif
                    end else begin
                        r_cur   <= net_next;
                        r_steps <= r_steps + ONE;
                    end
                end
`ifdef GSC_CYCLE_LEN_EN
                MEASURE: begin
                    r_cur <= net_next;
                    r_len <= r_len + ONE;
                end
`endif
                REPORT: if (w_hs) begin
                    if (r_kind == KIND_CYCLE) r_cycle <= r_cycle + ONE;
                    else                      r_fixed <= r_fixed + ONE;
                    if (r_iter != r_hi) r_iter <= r_iter + ONE;
                end
                default: ;
            endcase
        end
    end

    assign net_cur   = r_cur;
    assign res_valid = (r_state == REPORT);
    assign res_init  = r_init;
    assign res_kind  = r_kind;
    assign res_attr  = r_attr;
    assign res_steps = r_steps;
    assign fixed_cnt = r_fixed;
    assign cycle_cnt = r_cycle;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
`ifdef GSC_CYCLE_LEN_EN
    assign res_cyc_len = r_len;
`endif

endmodule
